// File: rtl/router_sync_if.sv
// router_sync_if
//   Bundles the signals between the router FSM / FIFO bank / destinations
//   and the router_sync steering stage.
//   Optional macro: ROUTER_SYNC_ADDR_ERR_EN adds the addr_err status bit.
//
//   Signals (direction as seen by router_sync, modport slave):
//     detect_add        in   header-decode strobe, latches data_in
//     data_in[1:0]      in   header destination address
//     write_enb_reg     in   FSM write request for the current byte
//     read_enb_0..2     in   destination read strobes
//     empty_0..2        in   FIFO empty flags
//     full_0..2         in   FIFO full flags
//     write_enb[2:0]    out  one-hot FIFO write enables
//     fifo_full         out  full flag of the addressed FIFO
//     vld_out_0..2      out  data-available to destinations
//     soft_reset_0..2   out  one-cycle FIFO flush pulses
//     addr_err          out  (macro only) last latched address was 2'b11
interface router_sync_if;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
`ifdef ROUTER_SYNC_ADDR_ERR_EN
  logic       addr_err;
`endif

  // Driver side: FSM, FIFO bank and destinations together.
  modport master (
    output detect_add, data_in, write_enb_reg,
    output read_enb_0, read_enb_1, read_enb_2,
    output empty_0, empty_1, empty_2,
    output full_0, full_1, full_2,
    input  write_enb, fifo_full,
    input  vld_out_0, vld_out_1, vld_out_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    , input addr_err
`endif
  );

  modport slave (
    input  detect_add, data_in, write_enb_reg,
    input  read_enb_0, read_enb_1, read_enb_2,
    input  empty_0, empty_1, empty_2,
    input  full_0, full_1, full_2,
    output write_enb, fifo_full,
    output vld_out_0, vld_out_1, vld_out_2,
    output soft_reset_0, soft_reset_1, soft_reset_2
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    , output addr_err
`endif
  );
endinterface

// File: rtl/router_sync.sv
// router_sync
//   Steering stage between the router FSM and the three output FIFOs.
//   Latches the header destination address, steers the FSM write strobe
//   to one FIFO, returns that FIFO's full flag, produces per-port valid
//   flags and runs a per-port read-timeout watchdog that pulses a flush.
//   Optional macro: ROUTER_SYNC_ADDR_ERR_EN -- flags address 2'b11 on
//   addr_err and stalls the FSM (fifo_full=1) instead of dropping bytes.
//
//   Ports:
//     clock  in   rising-edge clock
//     reset  in   synchronous reset, active-high, highest priority
//     bus    slave modport of router_sync_if (see that file)
//   Parameters:
//     TIMEOUT  consecutive unread-valid cycles before flush (2..63)
//     CNT_W    watchdog counter width, 2**CNT_W > TIMEOUT
module router_sync #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 6
) (
  input  logic          clock,
  input  logic          reset,
  router_sync_if.slave  bus
);

  localparam logic [CNT_W-1:0] LP_TC = CNT_W'(TIMEOUT - 1);

  logic [1:0]       r_addr;
  logic [CNT_W-1:0] r_cnt [3];
  logic [2:0]       r_soft_reset;

  logic [2:0] w_vld;
  logic [2:0] w_read;
  logic [2:0] w_full;
  logic [2:0] w_write_enb;
  logic       w_fifo_full;

  assign w_vld  = ~{bus.empty_2, bus.empty_1, bus.empty_0};
  assign w_read = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
  assign w_full = {bus.full_2, bus.full_1, bus.full_0};

  always_ff @(posedge clock) begin
    if (reset)
      r_addr <= 2'b00;
    else if (bus.detect_add)
      r_addr <= bus.data_in;
  end

`ifdef ROUTER_SYNC_ADDR_ERR_EN
  logic r_addr_err;

  always_ff @(posedge clock) begin
    if (reset)
      r_addr_err <= 1'b0;
    else if (bus.detect_add)
      r_addr_err <= (bus.data_in == 2'b11);
  end

  assign bus.addr_err = r_addr_err;
`endif

  // Steering uses the registered address, so a detect_add cycle that also
  // carries a write still goes to the previous destination.
  always_comb begin
    w_write_enb = 3'b000;
    w_fifo_full = 1'b0;
    case (r_addr)
      2'b00: begin
        w_write_enb = {2'b00, bus.write_enb_reg};
        w_fifo_full = w_full[0];
      end
      2'b01: begin
        w_write_enb = {1'b0, bus.write_enb_reg, 1'b0};
        w_fifo_full = w_full[1];
      end
      2'b10: begin
        w_write_enb = {bus.write_enb_reg, 2'b00};
        w_fifo_full = w_full[2];
      end
      default: begin
`ifdef ROUTER_SYNC_ADDR_ERR_EN
        // Hold the FSM off rather than silently discarding the packet.
        w_fifo_full = 1'b1;
`else
        w_fifo_full = 1'b0;
`endif
      end
    endcase
  end

  // Watchdog: a read or an empty FIFO restarts the count; reaching the
  // terminal count fires one flush pulse and starts a fresh window.
  always_ff @(posedge clock) begin
    for (int n = 0; n < 3; n++) begin
      if (reset || !w_vld[n] || w_read[n]) begin
        r_cnt[n]        <= '0;
        r_soft_reset[n] <= 1'b0;
      end else if (r_cnt[n] == LP_TC) begin
        r_cnt[n]        <= '0;
        r_soft_reset[n] <= 1'b1;
      end else begin
        r_cnt[n]        <= r_cnt[n] + 1'b1;
        r_soft_reset[n] <= 1'b0;
      end
    end
  end

  assign bus.write_enb    = w_write_enb;
  assign bus.fifo_full    = w_fifo_full;
  assign bus.vld_out_0    = w_vld[0];
  assign bus.vld_out_1    = w_vld[1];
  assign bus.vld_out_2    = w_vld[2];
  assign bus.soft_reset_0 = r_soft_reset[0];
  assign bus.soft_reset_1 = r_soft_reset[1];
  assign bus.soft_reset_2 = r_soft_reset[2];

endmodule

// File: tb/tb_router_sync.sv
// tb_router_sync
//   Self-checking bench for router_sync: a vector table for address
//   steering / full mux / valid flags, checked through an expectation
//   queue, plus hand-written watchdog sequences.
module tb_router_sync;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  router_sync_if bus();

  router_sync #(.TIMEOUT(30), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

`ifdef ROUTER_SYNC_ADDR_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic       det;
    logic [1:0] din;
    logic       wer;
    logic [2:0] full;   // {full_2, full_1, full_0}
    logic [2:0] empty;  // {empty_2, empty_1, empty_0}
    logic [2:0] exp_we;
    logic       exp_ff;
    logic [2:0] exp_vld;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [2:0] we;
    logic       ff;
    logic [2:0] vld;
    logic       err;
  } exp_t;

  vec_t vecs [15];
  exp_t sb_q [$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    bus.detect_add    = 1'b0;
    bus.data_in       = 2'b00;
    bus.write_enb_reg = 1'b0;
    bus.read_enb_0 = 1'b0; bus.read_enb_1 = 1'b0; bus.read_enb_2 = 1'b0;
    bus.empty_0    = 1'b1; bus.empty_1    = 1'b1; bus.empty_2    = 1'b1;
    bus.full_0     = 1'b0; bus.full_1     = 1'b0; bus.full_2     = 1'b0;
  endtask

  task automatic set_port(input int p, input logic empty, input logic rd);
    case (p)
      0: begin bus.empty_0 = empty; bus.read_enb_0 = rd; end
      1: begin bus.empty_1 = empty; bus.read_enb_1 = rd; end
      default: begin bus.empty_2 = empty; bus.read_enb_2 = rd; end
    endcase
  endtask

  function automatic logic get_sr(input int p);
    case (p)
      0: return bus.soft_reset_0;
      1: return bus.soft_reset_1;
      default: return bus.soft_reset_2;
    endcase
  endfunction

  // Runs n_edges clock edges on one port. Before edge e: read is high only
  // when e==read_at, the FIFO reads empty from edge empty_at on (0 = never),
  // and reset is high only when e==reset_at. Reports pulse edges seen.
  task automatic watch(input int port, input int n_edges, input int read_at,
                       input int empty_at, input int reset_at,
                       output int first, output int last, output int cnt);
    first = 0; last = 0; cnt = 0;
    for (int e = 1; e <= n_edges; e++) begin
      set_port(port, (empty_at != 0) && (e >= empty_at), e == read_at);
      reset = (e == reset_at);
      step();
      if (get_sr(port)) begin
        if (first == 0) first = e;
        last = e;
        cnt++;
      end
    end
    set_port(port, 1'b1, 1'b0);
    reset = 1'b0;
    step();
  endtask

  int first, last, cnt;

  initial begin
    //             det din   wer full    empty   we      ff      vld     err
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 3'b000, 3'b111, 3'b000, 1'b0,   3'b000, 1'b0};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 3'b001, 3'b110, 3'b001, 1'b1,   3'b001, 1'b0};
    vecs[2]  = '{1'b1, 2'b10, 1'b1, 3'b000, 3'b111, 3'b001, 1'b0,   3'b000, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 1'b1, 3'b100, 3'b011, 3'b100, 1'b1,   3'b100, 1'b0};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 3'b100, 3'b111, 3'b000, 1'b1,   3'b000, 1'b0};
    vecs[5]  = '{1'b1, 2'b01, 1'b0, 3'b000, 3'b111, 3'b000, 1'b0,   3'b000, 1'b0};
    vecs[6]  = '{1'b0, 2'b00, 1'b1, 3'b010, 3'b101, 3'b010, 1'b1,   3'b010, 1'b0};
    vecs[7]  = '{1'b0, 2'b00, 1'b1, 3'b011, 3'b111, 3'b010, 1'b1,   3'b000, 1'b0};
    vecs[8]  = '{1'b0, 2'b00, 1'b1, 3'b001, 3'b111, 3'b010, 1'b0,   3'b000, 1'b0};
    vecs[9]  = '{1'b1, 2'b00, 1'b1, 3'b010, 3'b111, 3'b010, 1'b1,   3'b000, 1'b0};
    vecs[10] = '{1'b0, 2'b00, 1'b1, 3'b010, 3'b111, 3'b001, 1'b0,   3'b000, 1'b0};
    vecs[11] = '{1'b1, 2'b11, 1'b1, 3'b000, 3'b111, 3'b001, 1'b0,   3'b000, 1'b0};
    vecs[12] = '{1'b0, 2'b00, 1'b1, 3'b111, 3'b111, 3'b000, ERR_EN, 3'b000, ERR_EN};
    vecs[13] = '{1'b1, 2'b10, 1'b0, 3'b000, 3'b111, 3'b000, ERR_EN, 3'b000, ERR_EN};
    vecs[14] = '{1'b0, 2'b00, 1'b1, 3'b000, 3'b111, 3'b100, 1'b0,   3'b000, 1'b0};

    drive_idle();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("soft_reset_after_rst", 0,
          {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0}, 3'b000);

    for (int i = 0; i < 15; i++) begin
      bus.detect_add    = vecs[i].det;
      bus.data_in       = vecs[i].din;
      bus.write_enb_reg = vecs[i].wer;
      {bus.full_2, bus.full_1, bus.full_0}    = vecs[i].full;
      {bus.empty_2, bus.empty_1, bus.empty_0} = vecs[i].empty;
      sb_q.push_back('{vecs[i].exp_we, vecs[i].exp_ff, vecs[i].exp_vld, vecs[i].exp_err});
      #1;
      if (sb_q.size() == 0) begin
        check("scoreboard_empty", i, 0, 1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("write_enb", i, bus.write_enb, e.we);
        check("fifo_full", i, bus.fifo_full, e.ff);
        check("vld_out",   i, {bus.vld_out_2, bus.vld_out_1, bus.vld_out_0}, e.vld);
`ifdef ROUTER_SYNC_ADDR_ERR_EN
        check("addr_err",  i, bus.addr_err, e.err);
`endif
      end
      step();
    end

    drive_idle();
    step();
    step();

    // Port 0 fires at edge 30; FIFO drains during the pulse -> no repeat.
    watch(0, 70, 0, 31, 0, first, last, cnt);
    check("p0_fire_edge", 0, first, 30);
    check("p0_fire_count", 0, cnt, 1);

    // Port 0 never drains: pulses every 30 edges.
    watch(0, 65, 0, 0, 0, first, last, cnt);
    check("p0_repeat_first", 0, first, 30);
    check("p0_repeat_last", 0, last, 60);
    check("p0_repeat_count", 0, cnt, 2);

    // Port 1 read at edge 20 restarts the window -> pulse at edge 50.
    watch(1, 60, 20, 0, 0, first, last, cnt);
    check("p1_read_abort_edge", 0, first, 50);
    check("p1_read_abort_count", 0, cnt, 1);

    // Port 1 empties at edge 25 -> no pulse.
    watch(1, 60, 0, 25, 0, first, last, cnt);
    check("p1_empty_abort_count", 0, cnt, 0);

    // Reset mid-count on port 2 with a non-zero address latched.
    bus.detect_add = 1'b1;
    bus.data_in    = 2'b10;
    step();
    bus.detect_add    = 1'b0;
    bus.write_enb_reg = 1'b1;
    #1;
    check("pre_reset_write_enb", 0, bus.write_enb, 3'b100);
    bus.write_enb_reg = 1'b0;
    watch(2, 65, 0, 0, 30, first, last, cnt);
    check("p2_reset_first", 0, first, 60);
    check("p2_reset_count", 0, cnt, 1);
    bus.write_enb_reg = 1'b1;
    bus.full_0        = 1'b1;
    #1;
    check("post_reset_write_enb", 0, bus.write_enb, 3'b001);
    check("post_reset_fifo_full", 0, bus.fifo_full, 1'b1);
    drive_idle();
    step();

    // Two ports reaching terminal count on the same edge.
    bus.empty_0 = 1'b0;
    bus.empty_1 = 1'b0;
    repeat (29) step();
    check("dual_before", 0, {bus.soft_reset_1, bus.soft_reset_0}, 2'b00);
    step();
    check("dual_fire", 0, {bus.soft_reset_1, bus.soft_reset_0}, 2'b11);
    step();
    check("dual_after", 0, {bus.soft_reset_1, bus.soft_reset_0}, 2'b00);
    drive_idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/router_sync.md
Name: router_sync

Overview:
- Synchroniser/steering stage directly upstream of the three router output FIFOs. It sits between the router FSM and the FIFO bank.
- Latches the 2-bit destination address from the packet header. It then steers the FSM's single write strobe to exactly one FIFO and returns that FIFO's full flag to the FSM.
- Generates per-port valid outputs from the FIFO empty flags.
- Runs a per-port read-timeout watchdog that pulses soft_reset to flush a FIFO whose destination has stopped reading.

Parameters:
- TIMEOUT, 30: consecutive unread-valid cycles before soft_reset fires; legal range 2..63.
- CNT_W, 6: timeout counter width; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-high.
- detect_add  in  1  header-decode strobe from the FSM; latches the address.
- data_in  in  2  header address bits [1:0].
- write_enb_reg  in  1  FSM write request for the current byte.
- read_enb_0 / read_enb_1 / read_enb_2  in  1 each  destination read strobes.
- empty_0 / empty_1 / empty_2  in  1 each  FIFO empty flags.
- full_0 / full_1 / full_2  in  1 each  FIFO full flags.
- write_enb  out  3  one-hot FIFO write enables; bit n drives FIFO n.
- fifo_full  out  1  full flag of the addressed FIFO.
- vld_out_0 / vld_out_1 / vld_out_2  out  1 each  data-available to destinations.
- soft_reset_0 / soft_reset_1 / soft_reset_2  out  1 each  registered one-cycle FIFO flush pulses.

Behaviour:
- Clock and reset: single clock domain, clock; reset synchronous, active-high; reset has priority over every other input.
- Address register addr[1:0]:
  - reset -> 2'b00.
  - Else if detect_add, addr <= data_in.
  - Else hold.
  - A new address is visible to write_enb/fifo_full in the cycle after the detect_add edge.
- write_enb (combinational from addr and write_enb_reg):
  - write_enb_reg=0 -> 3'b000.
  - Else addr 00 -> 001, 01 -> 010, 10 -> 100, 11 -> 000.
- fifo_full (combinational):
  - addr 00 -> full_0, 01 -> full_1, 10 -> full_2, 11 -> 0.
- vld_out_n = ~empty_n (combinational; no reset dependency beyond the FIFO's own).
- Timeout watchdog, independent per port n; registers cnt_n[CNT_W-1:0] and soft_reset_n. At each rising edge:
  - reset, or vld_out_n=0, or read_enb_n=1 -> cnt_n <= 0, soft_reset_n <= 0.
  - Else if cnt_n == TIMEOUT-1 -> cnt_n <= 0, soft_reset_n <= 1.
  - Else cnt_n <= cnt_n+1, soft_reset_n <= 0.
- Timeout timing:
  - soft_reset_n goes high at the TIMEOUT-th consecutive edge sampling vld=1/read=0, and stays high exactly one cycle.
  - If the FIFO does not empty after the pulse, counting restarts from 0 and fires again after another TIMEOUT edges.
  - A single read_enb_n cycle restarts the count from 0.
  - vld_out_n dropping at any point aborts the count.
- Reset values: addr=00, all cnt=0, all soft_reset=0.
  - Outputs after reset: write_enb=000 (when write_enb_reg=0), fifo_full=full_0.
  - Reset asserted mid-count clears the count and cancels any pending pulse.
- Simultaneous events:
  - detect_add together with write_enb_reg: write_enb uses the old addr that cycle.
  - Ports count independently; multiple soft_reset pulses may coincide.

Optional Feature:
- Macro: ROUTER_SYNC_ADDR_ERR_EN.
- When defined:
  - Adds output addr_err (1 bit, registered).
  - Set to 1 at the edge where detect_add latches data_in=2'b11.
  - Cleared by reset or by detect_add with a legal address.
  - While addr=11: write_enb=000 and fifo_full=1, which stalls the FSM.
- When undefined:
  - No addr_err port.
  - addr 11 yields write_enb=000 and fifo_full=0; bytes are silently dropped.

Test Plan:
- Address steering: reset 3 cycles; detect_add=1 with data_in=2'b10 for one cycle; then write_enb_reg=1 -> write_enb=3'b100 from the next cycle. Repeat with 00 -> 001 and 01 -> 010. write_enb_reg=0 -> 000.
- Full mux: addr=01, full_1=1, full_0=full_2=0 -> fifo_full=1; toggle full_0 only -> fifo_full unchanged.
- Timeout fire: empty_0=0 and read_enb_0=0 held -> soft_reset_0 high exactly one cycle, at the 30th edge; drive empty_0=1 during the pulse -> no further pulse.
- Timeout abort: empty_1=0; pulse read_enb_1 at edge 20 -> soft_reset_1 fires at edge 50, not 30. Separately, drive empty_1=1 at edge 25 -> no pulse.
- Reset mid-count: count port 2 to 29 edges; assert reset one cycle -> soft_reset_2 stays 0, addr=00, next pulse 30 edges after reset release.
- Invalid address: data_in=2'b11 with detect_add, write_enb_reg=1 -> write_enb=000.
  - Macro defined: addr_err=1 and fifo_full=1.
  - Macro undefined: fifo_full=0.
